// File: rtl/pong_score_if.sv
// pong_score_if: bundles the score keeper's game-side signals.
// master = ball controller / collision side, slave = pong_score_keeper.
interface pong_score_if #(
  parameter int SCORE_W = 4
);
  logic               p1_miss;
  logic               p2_miss;
  logic               game_reset;
  logic               serve_ack;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               point_pulse;
  logic               ball_freeze;
  logic               serve_req;
  logic               game_over;
  logic [1:0]         winner;
  logic [6:0]         seg;
  logic [1:0]         an;

  modport master (
    output p1_miss, p2_miss, game_reset, serve_ack,
    input  p1_score, p2_score, point_pulse, ball_freeze, serve_req,
           game_over, winner, seg, an
  );

  modport slave (
    input  p1_miss, p2_miss, game_reset, serve_ack,
    output p1_score, p2_score, point_pulse, ball_freeze, serve_req,
           game_over, winner, seg, an
  );
endinterface

// File: rtl/pong_score_keeper.sv
// pong_score_keeper: turns level miss flags into single point awards,
// keeps both saturating scores and sequences point -> freeze -> serve -> play.
// Optional 2-digit 7-segment scan is built only when SEG_DISPLAY_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// PLAY     | ball live, miss edges are scored
// HOLD     | ball frozen for HOLD_CYCLES after a point or replay
// SERVE    | ball frozen, serve_req high until serve_ack
// OVER     | a side reached MAX_SCORE; only game_reset leaves
module pong_score_keeper #(
  parameter int MAX_SCORE      = 9,
  parameter int SCORE_W        = 4,
  parameter int HOLD_CYCLES    = 50000000,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  pong_score_if.slave  bus
);

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam int                  HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0]  MAX_S     = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0]  LAST_S    = SCORE_W'(MAX_SCORE - 1);

  if (MAX_SCORE < 1 || MAX_SCORE > (2**SCORE_W) - 1 ||
      HOLD_CYCLES < 1 || REFRESH_CYCLES < 1) begin : g_param_check
    $error("pong_score_keeper: illegal parameter set");
  end

  logic [1:0]         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               point_pulse;
  logic [1:0]         winner;
  logic               p1_q;
  logic               p2_q;
  logic               p1_edge;
  logic               p2_edge;

  // Register the miss flags once and capture their rising edges as one-cycle events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      p1_edge <= 1'b0;
      p2_edge <= 1'b0;
    end else begin
      p1_q    <= bus.p1_miss;
      p2_q    <= bus.p2_miss;
      p1_edge <= bus.p1_miss & ~p1_q;
      p2_edge <= bus.p2_miss & ~p2_q;
    end
  end

  // Game sequencer: scoring, hold timer, serve handshake and game over.
  // Edge events arriving outside PLAY simply expire, so nothing is queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SERVE;
      hold_cnt    <= '0;
      p1_score    <= '0;
      p2_score    <= '0;
      point_pulse <= 1'b0;
      winner      <= 2'b00;
    end else begin
      point_pulse <= 1'b0;
      if (bus.game_reset) begin
        state    <= ST_SERVE;
        hold_cnt <= '0;
        p1_score <= '0;
        p2_score <= '0;
        winner   <= 2'b00;
      end else begin
        case (state)
          ST_PLAY: begin
            if (p1_edge && p2_edge) begin
              // simultaneous misses: replay without awarding anything
              state    <= ST_HOLD;
              hold_cnt <= HOLD_LOAD;
            end else if (p1_edge) begin
              if (p1_score != MAX_S) begin
                p1_score    <= p1_score + 1'b1;
                point_pulse <= 1'b1;
              end
              if (p1_score == LAST_S) begin
                state  <= ST_OVER;
                winner <= 2'b01;
              end else begin
                state    <= ST_HOLD;
                hold_cnt <= HOLD_LOAD;
              end
            end else if (p2_edge) begin
              if (p2_score != MAX_S) begin
                p2_score    <= p2_score + 1'b1;
                point_pulse <= 1'b1;
              end
              if (p2_score == LAST_S) begin
                state  <= ST_OVER;
                winner <= 2'b10;
              end else begin
                state    <= ST_HOLD;
                hold_cnt <= HOLD_LOAD;
              end
            end
          end
          ST_HOLD: begin
            if (hold_cnt == '0) begin
              state <= ST_SERVE;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          ST_SERVE: begin
            if (bus.serve_ack) begin
              state <= ST_PLAY;
            end
          end
          default: begin
            state <= ST_OVER;
          end
        endcase
      end
    end
  end

  assign bus.p1_score    = p1_score;
  assign bus.p2_score    = p2_score;
  assign bus.point_pulse = point_pulse;
  assign bus.winner      = winner;
  assign bus.ball_freeze = (state != ST_PLAY);
  assign bus.serve_req   = (state == ST_SERVE);
  assign bus.game_over   = (state == ST_OVER);

`ifdef SEG_DISPLAY_EN
  localparam int                 REF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [REF_W-1:0]   REF_LOAD = REF_W'(REFRESH_CYCLES - 1);

  logic [REF_W-1:0] ref_cnt;
  logic             digit_sel;
  logic [31:0]      shown;
  logic [6:0]       seg_dec;
  logic [6:0]       seg_q;
  logic [1:0]       an_q;

  // Refresh down-counter: flip the active digit on terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt   <= REF_LOAD;
      digit_sel <= 1'b0;
    end else if (ref_cnt == '0) begin
      ref_cnt   <= REF_LOAD;
      digit_sel <= ~digit_sel;
    end else begin
      ref_cnt <= ref_cnt - 1'b1;
    end
  end

  // Decode the selected score; segment order is {g,f,e,d,c,b,a}, active low.
  always_comb begin
    shown   = digit_sel ? 32'(p2_score) : 32'(p1_score);
    seg_dec = 7'h3F;
    case (shown)
      32'd0:   seg_dec = 7'h40;
      32'd1:   seg_dec = 7'h79;
      32'd2:   seg_dec = 7'h24;
      32'd3:   seg_dec = 7'h30;
      32'd4:   seg_dec = 7'h19;
      32'd5:   seg_dec = 7'h12;
      32'd6:   seg_dec = 7'h02;
      32'd7:   seg_dec = 7'h78;
      32'd8:   seg_dec = 7'h00;
      32'd9:   seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
  end

  // Register segments and digit enables together so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h7F;
      an_q  <= 2'b11;
    end else begin
      seg_q <= seg_dec;
      an_q  <= digit_sel ? 2'b01 : 2'b10;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
`else
  assign bus.seg = 7'h7F;
  assign bus.an  = 2'b11;
`endif

endmodule

// File: tb/tb_pong_score_keeper.sv
// tb_pong_score_keeper: directed bench for pong_score_keeper (HOLD_CYCLES=4).
module tb_pong_score_keeper;
  localparam int SW   = 4;
  localparam int HOLD = 4;
  localparam int REF  = 2;
  localparam int MAX  = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;

  pong_score_if #(.SCORE_W(SW)) bus ();

  pong_score_keeper #(
    .MAX_SCORE(MAX), .SCORE_W(SW), .HOLD_CYCLES(HOLD), .REFRESH_CYCLES(REF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.point_pulse === 1'b1) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_p1"},     32'(bus.p1_score), 0);
    chk({tag, "_p2"},     32'(bus.p2_score), 0);
    chk({tag, "_pulse"},  32'(bus.point_pulse), 0);
    chk({tag, "_freeze"}, 32'(bus.ball_freeze), 1);
    chk({tag, "_req"},    32'(bus.serve_req), 1);
    chk({tag, "_over"},   32'(bus.game_over), 0);
    chk({tag, "_winner"}, 32'(bus.winner), 0);
    chk({tag, "_seg"},    32'(bus.seg), 32'h7F);
    chk({tag, "_an"},     32'(bus.an), 32'h3);
  endtask

  task automatic do_serve();
    for (int i = 0; i < 20 && bus.serve_req !== 1'b1; i++) tick();
    chk("serve_req_seen", 32'(bus.serve_req), 1);
    bus.serve_ack = 1'b1;
    tick();
    bus.serve_ack = 1'b0;
    chk("play_freeze", 32'(bus.ball_freeze), 0);
    chk("play_req",    32'(bus.serve_req), 0);
  endtask

  // one clean miss edge in PLAY; checks the two-cycle latency and the new scores
  task automatic award(input bit side2, input int exp1, input int exp2);
    if (side2) bus.p2_miss = 1'b1; else bus.p1_miss = 1'b1;
    tick();
    chk("award_no_early_pulse", 32'(bus.point_pulse), 0);
    tick();
    chk("award_p1",     32'(bus.p1_score), 32'(exp1));
    chk("award_p2",     32'(bus.p2_score), 32'(exp2));
    chk("award_pulse",  32'(bus.point_pulse), 1);
    chk("award_freeze", 32'(bus.ball_freeze), 1);
    bus.p1_miss = 1'b0;
    bus.p2_miss = 1'b0;
  endtask

  initial begin
    logic [1:0] cur_an;
    bus.p1_miss    = 1'b0;
    bus.p2_miss    = 1'b0;
    bus.game_reset = 1'b0;
    bus.serve_ack  = 1'b0;

    // reset values
    ticks(2);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // held p1_miss scores once; serve_ack during HOLD is ignored; HOLD lasts 4 cycles
    do_serve();
    pulses = 0;
    bus.p1_miss = 1'b1;
    tick();
    chk("t1_latency_p1", 32'(bus.p1_score), 0);
    tick();
    chk("t1_p1",     32'(bus.p1_score), 1);
    chk("t1_pulse",  32'(bus.point_pulse), 1);
    chk("t1_freeze", 32'(bus.ball_freeze), 1);
    chk("t1_req",    32'(bus.serve_req), 0);
    bus.serve_ack = 1'b1;
    tick();
    bus.serve_ack = 1'b0;
    chk("t1_pulse_single", 32'(bus.point_pulse), 0);
    chk("t1_ack_ignored",  32'(bus.ball_freeze), 1);
    ticks(2);
    chk("t2_hold_freeze", 32'(bus.ball_freeze), 1);
    chk("t2_hold_req",    32'(bus.serve_req), 0);
    bus.p1_miss = 1'b0;
    tick();
    chk("t2_serve_req", 32'(bus.serve_req), 1);
    chk("t1_pulse_count", 32'(pulses), 1);
    chk("t1_p1_held", 32'(bus.p1_score), 1);
    do_serve();

    // simultaneous misses: replay through HOLD and SERVE
    bus.p1_miss = 1'b1;
    bus.p2_miss = 1'b1;
    ticks(2);
    chk("t3_p1",     32'(bus.p1_score), 1);
    chk("t3_p2",     32'(bus.p2_score), 0);
    chk("t3_pulse",  32'(bus.point_pulse), 0);
    chk("t3_freeze", 32'(bus.ball_freeze), 1);
    ticks(3);
    chk("t3_hold_req", 32'(bus.serve_req), 0);
    tick();
    chk("t3_serve_req", 32'(bus.serve_req), 1);

    // p2_miss already high when PLAY starts must not score
    bus.p1_miss = 1'b0;
    ticks(2);
    do_serve();
    ticks(3);
    chk("stale_p2",     32'(bus.p2_score), 0);
    chk("stale_freeze", 32'(bus.ball_freeze), 0);
    bus.p2_miss = 1'b0;
    tick();
    award(1'b1, 1, 1);

    // run p2 up to MAX_SCORE
    for (int k = 2; k <= MAX; k++) begin
      do_serve();
      award(1'b1, 1, k);
    end
    chk("t4_over",   32'(bus.game_over), 1);
    chk("t4_winner", 32'(bus.winner), 32'h2);
    chk("t4_req",    32'(bus.serve_req), 0);
    bus.p2_miss = 1'b1;
    ticks(3);
    chk("t4_sat_p2",    32'(bus.p2_score), 9);
    chk("t4_sat_pulse", 32'(bus.point_pulse), 0);
    chk("t4_sat_over",  32'(bus.game_over), 1);
    bus.p2_miss = 1'b0;

`ifdef SEG_DISPLAY_EN
    // p1=1 (7'h79) on an=10, p2=9 (7'h10) on an=01, two-cycle dwell
    cur_an = bus.an;
    for (int i = 0; i < 4 && bus.an === cur_an; i++) tick();
    cur_an = bus.an;
    chk("seg_an_valid", 32'((cur_an == 2'b10) || (cur_an == 2'b01)), 1);
    chk("seg_digit", 32'(bus.seg), (cur_an == 2'b10) ? 32'h79 : 32'h10);
    tick();
    chk("seg_dwell", 32'(bus.an), 32'(cur_an));
    tick();
    chk("seg_toggle", 32'(bus.an), 32'(~cur_an));
    chk("seg_digit2", 32'(bus.seg), (cur_an == 2'b10) ? 32'h10 : 32'h79);
`else
    cur_an = 2'b11;
    ticks(3);
    chk("seg_off", 32'(bus.seg), 32'h7F);
    chk("an_off",  32'(bus.an), 32'(cur_an));
`endif

    // game_reset leaves OVER
    bus.game_reset = 1'b1;
    tick();
    bus.game_reset = 1'b0;
    chk("gr_p1",     32'(bus.p1_score), 0);
    chk("gr_p2",     32'(bus.p2_score), 0);
    chk("gr_over",   32'(bus.game_over), 0);
    chk("gr_winner", 32'(bus.winner), 0);
    chk("gr_req",    32'(bus.serve_req), 1);

    // async reset mid-HOLD
    do_serve();
    award(1'b0, 1, 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    // game_reset beats a coincident miss edge
    do_serve();
    bus.p1_miss = 1'b1;
    tick();
    bus.game_reset = 1'b1;
    tick();
    bus.game_reset = 1'b0;
    chk("grm_p1",    32'(bus.p1_score), 0);
    chk("grm_pulse", 32'(bus.point_pulse), 0);
    chk("grm_req",   32'(bus.serve_req), 1);
    bus.p1_miss = 1'b0;
    ticks(3);
    chk("grm_p1_later", 32'(bus.p1_score), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
